cu_pipe: RTL and testbench

//  Pipelined successor of the combinational decode control unit. Decodes the IF/ID instruction

---
 rtl/cu_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_cu_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cu_pipe.sv
// rtl/cu_pipe.sv - pipelined decode control unit: IF/ID decode into ID/EX with hazard, flush, freeze, halt
// Optional RV32M decode with multi-cycle EX stall is built when CU_MULDIV_EN is defined.
module cu_pipe #(
  parameter int RF_AW   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic             flush,
  input  logic             dmem_stall,
  input  logic             imem_stall,
  output logic             pc_en,
  output logic             ex_valid,
  output logic [15:0]      ex_cw,
  output logic [4:0]       ex_aluop,
  output logic [RF_AW-1:0] ex_rd,
  output logic [RF_AW-1:0] ex_rs1,
  output logic [RF_AW-1:0] ex_rs2,
  output logic             md_busy,
  output logic             illegal
);

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010;

  typedef enum logic [1:0] {
    ST_RUN, ST_HALT
`ifdef CU_MULDIV_EN
    , ST_MDWAIT
`endif
  } state_t;

  function automatic logic [4:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  assign opc   = if_instr[6:0];
  assign rd_f  = if_instr[11:7];
  assign f3    = if_instr[14:12];
  assign rs1_f = if_instr[19:15];
  assign rs2_f = if_instr[24:20];
  assign f7    = if_instr[31:25];

  logic        md_op, rd1_en, rd2_en, src1, src2, jump, mwr, mrd, ldq, stq, rwr, bad;
  logic [2:0]  br;
  logic [1:0]  m2r;
  logic [4:0]  aop;
  logic [15:0] dec_cw;
  logic [4:0]  dec_aop;
  logic        dec_ill;

  always_comb begin
    md_op = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0; src1 = 1'b0; src2 = 1'b0;
    jump = 1'b0; mwr = 1'b0; mrd = 1'b0; ldq = 1'b0; stq = 1'b0; rwr = 1'b0;
    bad = 1'b0; br = 3'b000; m2r = 2'b00; aop = OP_ADD;
    case (opc)
      7'b0110111: begin src2 = 1'b1; rwr = 1'b1; end
      7'b0010111: begin src1 = 1'b1; src2 = 1'b1; rwr = 1'b1; end
      7'b1101111: begin src1 = 1'b1; src2 = 1'b1; jump = 1'b1; m2r = 2'b10; rwr = 1'b1; end
      7'b1100111: begin rd1_en = 1'b1; src2 = 1'b1; jump = 1'b1; m2r = 2'b10; rwr = 1'b1; end
      7'b1100011: begin
        rd1_en = 1'b1; rd2_en = 1'b1; aop = OP_SUB;
        case (f3)
          3'b000:  br = 3'b001;
          3'b001:  br = 3'b010;
          3'b100:  br = 3'b011;
          3'b101:  br = 3'b100;
          3'b110:  br = 3'b101;
          3'b111:  br = 3'b110;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin rd1_en = 1'b1; src2 = 1'b1; mrd = 1'b1; ldq = 1'b1; m2r = 2'b01; rwr = 1'b1; end
      7'b0100011: begin rd1_en = 1'b1; rd2_en = 1'b1; src2 = 1'b1; mwr = 1'b1; stq = 1'b1; end
      7'b0010011: begin rd1_en = 1'b1; src2 = 1'b1; rwr = 1'b1; aop = f3_op(f3, if_instr[30]); end
      7'b0110011: begin
        rd1_en = 1'b1; rd2_en = 1'b1; rwr = 1'b1;
        if (f7 == 7'b0000000) aop = f3_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && f3 == 3'b000) aop = OP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) aop = OP_SRA;
`ifdef CU_MULDIV_EN
        else if (f7 == 7'b0000001) begin md_op = 1'b1; aop = {2'b10, f3}; end
`endif
        else bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // register fields wider than the implemented file (RV32E) are illegal
    if ((rd1_en && |(rs1_f >> RF_AW)) || (rd2_en && |(rs2_f >> RF_AW)) || (rwr && |(rd_f >> RF_AW)))
      bad = 1'b1;
    if (rd_f == 5'd0) rwr = 1'b0;
    dec_ill = bad;
    dec_cw  = bad ? 16'h0000 :
              {md_op, rd1_en, rd2_en, src1, src2, br, jump, mwr, mrd, ldq, stq, m2r, rwr};
    dec_aop = bad ? 5'b00000 : aop;
  end

  state_t           state_q;
  logic             ex_valid_q, illegal_q;
  logic [15:0]      ex_cw_q;
  logic [4:0]       ex_aluop_q;
  logic [RF_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;

`ifdef CU_MULDIV_EN
  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  logic [CNT_W-1:0] md_cnt_q, md_lat_d;
  logic             md_busy_q;
  assign md_lat_d = f3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign md_busy  = md_busy_q;
`else
  // latency parameters only shape the M-op datapath
  assign md_busy  = 1'b0 & (MUL_LAT[0] ^ DIV_LAT[0]);
`endif

  logic dec_ok, load_use;
  assign dec_ok   = if_valid && !dec_ill;
  assign load_use = ex_valid_q && ex_cw_q[4] && (ex_rd_q != '0) && dec_ok &&
                    ((dec_cw[14] && rs1_f[RF_AW-1:0] == ex_rd_q) ||
                     (dec_cw[13] && rs2_f[RF_AW-1:0] == ex_rd_q));

  always_comb begin
    pc_en = 1'b1;
    if (flush)                      pc_en = 1'b1;
    else if (dmem_stall)            pc_en = 1'b0;
    else if (state_q != ST_RUN)     pc_en = 1'b0;
    else if (if_valid && dec_ill)   pc_en = 1'b0;
    else if (load_use)              pc_en = 1'b0;
    else                            pc_en = !imem_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      ex_cw_q    <= '0;
      ex_aluop_q <= '0;
      ex_rd_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      illegal_q  <= 1'b0;
`ifdef CU_MULDIV_EN
      md_cnt_q   <= '0;
      md_busy_q  <= 1'b0;
`endif
    end else if (flush) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      ex_cw_q    <= '0;
      ex_aluop_q <= '0;
      illegal_q  <= 1'b0;
`ifdef CU_MULDIV_EN
      md_cnt_q   <= '0;
      md_busy_q  <= 1'b0;
`endif
    end else if (!dmem_stall) begin
      if (state_q == ST_HALT) begin
        ex_valid_q <= 1'b0;
`ifdef CU_MULDIV_EN
      end else if (state_q == ST_MDWAIT) begin
        md_cnt_q <= md_cnt_q - CNT_W'(1);
        if (md_cnt_q == CNT_W'(1)) begin
          state_q   <= ST_RUN;
          md_busy_q <= 1'b0;
        end
`endif
      end else if (if_valid && dec_ill) begin
        state_q    <= ST_HALT;
        illegal_q  <= 1'b1;
        ex_valid_q <= 1'b0;
        ex_cw_q    <= '0;
        ex_aluop_q <= '0;
      end else if (load_use || !if_valid || imem_stall) begin
        ex_valid_q <= 1'b0;
        ex_cw_q    <= '0;
        ex_aluop_q <= '0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_cw_q    <= dec_cw;
        ex_aluop_q <= dec_aop;
        ex_rd_q    <= rd_f[RF_AW-1:0];
        ex_rs1_q   <= rs1_f[RF_AW-1:0];
        ex_rs2_q   <= rs2_f[RF_AW-1:0];
`ifdef CU_MULDIV_EN
        if (dec_cw[15] && md_lat_d != '0) begin
          state_q   <= ST_MDWAIT;
          md_cnt_q  <= md_lat_d;
          md_busy_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_cw    = ex_cw_q;
  assign ex_aluop = ex_aluop_q;
  assign ex_rd    = ex_rd_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_cu_pipe.sv
// tb/tb_cu_pipe.sv - directed-vector bench for cu_pipe with hand-computed control words
module tb_cu_pipe;
  localparam logic [31:0] I_BLT   = 32'h0020C063;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD   = 32'h00228333;
  localparam logic [31:0] I_ADDI0 = 32'h00000013;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_BBR   = 32'h0020A063;
  localparam logic [31:0] I_MUL   = 32'h022081B3;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        if_valid = 1'b0, flush = 1'b0, dmem_stall = 1'b0, imem_stall = 1'b0;
  logic [31:0] if_instr = '0;
  logic        pc_en, ex_valid, md_busy, illegal;
  logic [15:0] ex_cw;
  logic [4:0]  ex_aluop, ex_rd, ex_rs1, ex_rs2;
  int          n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  cu_pipe dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .flush(flush),
    .dmem_stall(dmem_stall), .imem_stall(imem_stall), .pc_en(pc_en), .ex_valid(ex_valid),
    .ex_cw(ex_cw), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .md_busy(md_busy), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    if_valid = v;
    if_instr = ins;
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_cw", ex_cw, 0);
    check("rst_ex_aluop", ex_aluop, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_illegal", illegal, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_pc_en", pc_en, 1);
    tick;
    rst_n = 1'b1;

    drive(1, I_BLT);
    check("blt_pc_en", pc_en, 1);
    tick;
    check("blt_valid", ex_valid, 1);
    check("blt_cw", ex_cw, 16'h6300);
    check("blt_aluop", ex_aluop, 5'b00010);
    check("blt_rs1", ex_rs1, 1);
    check("blt_rs2", ex_rs2, 2);

    drive(1, I_LW);
    tick;
    check("lw_cw", ex_cw, 16'h4833);
    check("lw_rd", ex_rd, 5);
    check("lw_aluop", ex_aluop, 5'b00001);
    drive(1, I_ADD);
    check("lu_pc_en", pc_en, 0);
    tick;
    check("lu_bubble", ex_valid, 0);
    check("lu_pc_en_after", pc_en, 1);
    tick;
    check("add_valid", ex_valid, 1);
    check("add_rd", ex_rd, 6);
    check("add_cw", ex_cw, 16'h6001);

    drive(1, I_LW);
    tick;
    drive(1, I_ADD);
    flush = 1'b1;
    #1;
    check("flush_lu_pc_en", pc_en, 1);
    tick;
    flush = 1'b0;
    check("flush_lu_valid", ex_valid, 0);

    drive(1, I_BLT);
    tick;
    dmem_stall = 1'b1;
    drive(1, I_ADD);
    check("dmem_pc_en", pc_en, 0);
    tick;
    check("dmem_hold_cw", ex_cw, 16'h6300);
    check("dmem_hold_valid", ex_valid, 1);
    dmem_stall = 1'b0;
    imem_stall = 1'b1;
    drive(1, I_ADD);
    check("imem_pc_en", pc_en, 0);
    tick;
    check("imem_bubble", ex_valid, 0);
    imem_stall = 1'b0;

    drive(1, I_ADDI0);
    tick;
    check("rd0_cw", ex_cw, 16'h4800);
    drive(1, I_SRAI);
    tick;
    check("srai_cw", ex_cw, 16'h4801);
    check("srai_aluop", ex_aluop, 5'b01000);
    check("srai_rd", ex_rd, 1);

    drive(1, I_BAD);
    check("ill_pc_en", pc_en, 0);
    tick;
    check("ill_flag", illegal, 1);
    check("ill_valid", ex_valid, 0);
    for (int i = 0; i < 10; i++) begin
      check("halt_illegal", illegal, 1);
      check("halt_pc_en", pc_en, 0);
      tick;
    end
    drive(0, '0);
    flush = 1'b1;
    #1;
    check("halt_flush_pc_en", pc_en, 1);
    tick;
    flush = 1'b0;
    check("halt_cleared", illegal, 0);
    check("run_pc_en", pc_en, 1);

    drive(1, I_BBR);
    tick;
    check("bbr_illegal", illegal, 1);
    drive(0, '0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("bbr_cleared", illegal, 0);

`ifdef CU_MULDIV_EN
    drive(1, I_MUL);
    check("mul_pc_en", pc_en, 1);
    tick;
    check("mul_aluop", ex_aluop, 5'b10000);
    check("mul_md_bit", ex_cw[15], 1);
    drive(1, I_ADD);
    for (int i = 0; i < 3; i++) begin
      check("mul_busy", md_busy, 1);
      check("mul_pc_en_stall", pc_en, 0);
      tick;
    end
    check("mul_done", md_busy, 0);
    check("mul_pc_en_done", pc_en, 1);
`else
    drive(1, I_MUL);
    check("mul_pc_en", pc_en, 0);
    tick;
    check("mul_illegal", illegal, 1);
    check("mul_md_bit", ex_cw[15], 0);
    check("mul_busy", md_busy, 0);
    drive(0, '0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
`endif

    drive(1, I_ADD);
    tick;
    check("pre_rst_valid", ex_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_cw", ex_cw, 0);
    check("mid_rst_illegal", illegal, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
